// File: rtl/gcd_arbiter_if.sv
// Requester-side bundle for gcd_arbiter: per-requester req/operands in, grant/done/result out.
// Handshake: a requester raises req with stable operands, is granted, receives a one-cycle done, then drops req in that done cycle.
interface gcd_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] a_in;
    logic [N_REQ*WIDTH-1:0] b_in;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       done;
    logic [WIDTH-1:0]       result;
    logic                   err;
    logic                   busy;

    modport master (
        output req, a_in, b_in,
        input  grant, done, result, err, busy
    );

    modport slave (
        input  req, a_in, b_in,
        output grant, done, result, err, busy
    );
endinterface

// File: rtl/gcd_arbiter.sv
// Round-robin scheduler sharing one subtractive GCD engine among N_REQ requesters.
// Optional engine watchdog enabled by defining GCD_ARB_TIMEOUT_EN.
module gcd_arbiter #(
    parameter int N_REQ          = 4,
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             reset,
    gcd_arbiter_if.slave     bus,
    output logic             eng_start,
    output logic [WIDTH-1:0] eng_a,
    output logic [WIDTH-1:0] eng_b,
    input  logic             eng_busy,
    input  logic [WIDTH-1:0] eng_result,
    output logic [2:0]       dbg_state
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RESP      = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    ptr, owner, win;
    logic             any_req;
    logic [WIDTH-1:0] win_a, win_b;
    logic             win_zero;
    logic             timed_out;
    logic [N_REQ-1:0] grant_q, done_q, win_oh;
    logic [WIDTH-1:0] result_q;
    logic             err_q;
    int               idx;

    // Scan downwards so the requester closest to ptr is the last, winning assignment.
    always_comb begin
        any_req = 1'b0;
        win     = '0;
        idx     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (bus.req[idx]) begin
                any_req = 1'b1;
                win     = idx[PW-1:0];
            end
        end
    end

    assign win_a    = bus.a_in[win*WIDTH +: WIDTH];
    assign win_b    = bus.b_in[win*WIDTH +: WIDTH];
    assign win_zero = (win_a == '0) || (win_b == '0);

    always_comb begin
        win_oh      = '0;
        win_oh[win] = 1'b1;
    end

`ifdef GCD_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            wd_cnt <= '0;
        else if (state == S_WAIT_BUSY || state == S_WAIT_DONE)
            wd_cnt <= wd_cnt + 16'd1;
        else
            wd_cnt <= '0;
    end

    assign timed_out = ((wd_cnt + 16'd1) == 16'(TIMEOUT_CYCLES));
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (any_req) state_nxt = win_zero ? S_RESP : S_ISSUE;
            S_ISSUE:     state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (timed_out)     state_nxt = S_RESP;
                else if (eng_busy) state_nxt = S_WAIT_DONE;
            end
            // Engine completion takes priority over a watchdog expiring in the same cycle.
            S_WAIT_DONE: if (!eng_busy || timed_out) state_nxt = S_RESP;
            S_RESP:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            ptr      <= '0;
            owner    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            eng_a    <= '0;
            eng_b    <= '0;
        end else begin
            state  <= state_nxt;
            done_q <= '0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner   <= win;
                        grant_q <= win_oh;
                        eng_a   <= win_a;
                        eng_b   <= win_b;
                        err_q   <= 1'b0;
                        if (win_zero) result_q <= win_a | win_b;
                    end
                end
                S_WAIT_BUSY: begin
                    if (timed_out) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!eng_busy) begin
                        result_q <= eng_result;
                    end else if (timed_out) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                    end
                end
                S_RESP: begin
                    done_q  <= grant_q;
                    grant_q <= '0;
                    ptr     <= (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign eng_start  = (state == S_ISSUE);
    assign dbg_state  = state;
    assign bus.grant  = grant_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.err    = err_q;
    assign bus.busy   = (state != S_IDLE);
endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter with a behavioural subtractive GCD engine.
// Covers single jobs, zero operands, round-robin order, mid-job reset and the watchdog build option.
module tb_gcd_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gcd_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    logic         eng_start;
    logic [W-1:0] eng_a, eng_b;
    logic         eng_busy;
    logic [W-1:0] eng_result;
    logic [2:0]   dbg_state;

    gcd_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .eng_start  (eng_start),
        .eng_a      (eng_a),
        .eng_b      (eng_b),
        .eng_busy   (eng_busy),
        .eng_result (eng_result),
        .dbg_state  (dbg_state)
    );

    // Engine model: latches operands on start, one subtraction per cycle, hang keeps it busy.
    logic [W-1:0] em_a, em_b, em_res;
    logic         em_busy;
    logic         hang;

    always @(posedge clk) begin
        if (reset) begin
            em_busy <= 1'b0;
            em_a    <= '0;
            em_b    <= '0;
            em_res  <= '0;
        end else if (eng_start) begin
            em_a    <= eng_a;
            em_b    <= eng_b;
            em_busy <= 1'b1;
        end else if (em_busy && !hang) begin
            if (em_a == em_b) begin
                em_busy <= 1'b0;
                em_res  <= em_a;
            end else if (em_a > em_b) begin
                em_a <= em_a - em_b;
            end else begin
                em_b <= em_b - em_a;
            end
        end
    end

    assign eng_busy   = em_busy;
    assign eng_result = em_res;

    int n_start = 0;
    always @(posedge clk) if (eng_start) n_start <= n_start + 1;

    // Scoreboard state
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] exp_q[$];
    int           order_q[$];

    typedef struct {
        int           idx;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        int           exp_starts;
        int           exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        hang     = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_job(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_res, input int exp_starts,
                           input int exp_lat, input logic exp_err);
        int             s0, cyc;
        bit             got;
        logic [N-1:0]   oh;
        oh      = '0;
        oh[idx] = 1'b1;
        @(negedge clk);
        bus.req              = '0;
        bus.req[idx]         = 1'b1;
        bus.a_in[idx*W +: W] = a;
        bus.b_in[idx*W +: W] = b;
        s0  = n_start;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("grant_after_req", bus.grant, oh);
                bus.a_in[idx*W +: W] = $urandom;
                bus.b_in[idx*W +: W] = $urandom;
            end
            if (bus.done != '0) got = 1'b1;
        end
        check("done_seen", got, 1);
        if (got) begin
            check("done_onehot", bus.done, oh);
            check("result", bus.result, exp_res);
            check("err", bus.err, exp_err);
            check("eng_start_count", n_start - s0, exp_starts);
            check("grant_cleared", bus.grant, 0);
            if (exp_lat > 0) check("latency", cyc, exp_lat);
        end
        bus.req[idx] = 1'b0;
    endtask

    initial begin
        int cyc, ndone, s0, pulses;
        bit reached;
        vecs[0] = '{0, 48,  18, 6,  1, -1};
        vecs[1] = '{2, 0,   35, 35, 0, 2};
        vecs[2] = '{3, 0,   0,  0,  0, 2};
        vecs[3] = '{1, 21,  14, 7,  1, -1};
        vecs[4] = '{3, 17,  5,  1,  1, -1};
        vecs[5] = '{1, 35,  0,  35, 0, 2};

        reset = 1'b1;
        do_reset();

        // Reset values
        check("rst_grant", bus.grant, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_err", bus.err, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_eng_start", eng_start, 0);
        check("rst_eng_a", eng_a, 0);
        check("rst_eng_b", eng_b, 0);

        foreach (vecs[i])
            run_job(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].exp_res,
                    vecs[i].exp_starts, vecs[i].exp_lat, 1'b0);

        // Fairness: all requesters at once after reset, ptr starts at 0
        do_reset();
        exp_q   = '{W'(4), W'(3), W'(7), W'(25)};
        order_q = '{0, 1, 2, 3};
        @(negedge clk);
        bus.a_in = {W'(100), W'(7), W'(9), W'(12)};
        bus.b_in = {W'(75),  W'(7), W'(6), W'(8)};
        bus.req  = '1;
        cyc   = 0;
        ndone = 0;
        while (ndone < 4 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (bus.done != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (bus.done[i]) begin
                        check("fair_order", i, order_q.pop_front());
                        check("fair_result", bus.result, exp_q.pop_front());
                        bus.req[i] = 1'b0;
                    end
                end
                ndone++;
            end
        end
        check("fair_done_count", ndone, 4);

        // Reset while the engine is running
        @(negedge clk);
        bus.req        = '0;
        bus.req[0]     = 1'b1;
        bus.a_in[0+:W] = 100;
        bus.b_in[0+:W] = 3;
        cyc     = 0;
        reached = 1'b0;
        while (!reached && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (dbg_state == 3'd3) reached = 1'b1;
        end
        check("reached_wait_done", reached, 1);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        bus.req = '0;
        check("midrst_grant", bus.grant, 0);
        check("midrst_busy", bus.busy, 0);
        pulses = 0;
        s0     = n_start;
        repeat (40) begin
            @(negedge clk);
            if (bus.done != '0) pulses++;
        end
        check("midrst_no_done", pulses, 0);
        check("midrst_no_start", n_start - s0, 0);
        run_job(1, 21, 14, 7, 1, -1, 1'b0);

        // Engine that never finishes
        do_reset();
        hang = 1'b1;
`ifdef GCD_ARB_TIMEOUT_EN
        run_job(0, 48, 18, 0, 1, 19, 1'b1);
`else
        @(negedge clk);
        bus.req[0]     = 1'b1;
        bus.a_in[0+:W] = 48;
        bus.b_in[0+:W] = 18;
        pulses = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bus.done != '0) pulses++;
        end
        check("hang_no_done", pulses, 0);
        check("hang_still_busy", bus.busy, 1);
`endif
        do_reset();
        run_job(2, 9, 6, 3, 1, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
